// File: rtl/mem_dma_engine_if.sv
// Memory-port bundle between the DMA engine and main memory.
// The master drives write enable, address and write data; the slave returns combinational read data.
`timescale 1ns/1ps
interface mem_dma_engine_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              mem_write_en;
   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_write_data;
   logic [DATA_W-1:0] mem_data_in;

   modport master (
      output mem_write_en,
      output mem_address,
      output mem_write_data,
      input  mem_data_in
   );

   modport slave (
      input  mem_write_en,
      input  mem_address,
      input  mem_write_data,
      output mem_data_in
   );
endinterface

// File: rtl/mem_dma_engine.sv
// Block copy / block fill DMA engine acting as a second master on a single-port word memory.
// Optional macro MEM_DMA_CHECKSUM_EN adds a running modulo sum of all written words.
`timescale 1ns/1ps
module mem_dma_engine #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              halt_sys,
   input  logic              start,
   input  logic              fill_mode,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [15:0]       length,
   input  logic [DATA_W-1:0] fill_value,
   mem_dma_engine_if.master  mem_bus,
   output logic              busy,
   output logic              done
`ifdef MEM_DMA_CHECKSUM_EN
   ,
   output logic [DATA_W-1:0] checksum
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] src_ptr_q;
   logic [ADDR_W-1:0] dst_ptr_q;
   logic [15:0]       remaining_q;
   logic              fill_mode_q;
   logic [DATA_W-1:0] fill_value_q;
   logic [DATA_W-1:0] data_buf_q;
   logic [ADDR_W-1:0] mem_address_q;
   logic              write_en_q;
   logic              busy_q;
   logic              done_q;

   logic [ADDR_W-1:0] src_ptr_d;
   logic [ADDR_W-1:0] dst_ptr_d;

   // Pointer increments wrap naturally at the address width.
   assign src_ptr_d = src_ptr_q + ADDR_W'(1);
   assign dst_ptr_d = dst_ptr_q + ADDR_W'(1);

   // Transfer FSM; outputs are set up at the edge that enters each state so they are valid for the whole cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         src_ptr_q     <= '0;
         dst_ptr_q     <= '0;
         remaining_q   <= 16'd0;
         fill_mode_q   <= 1'b0;
         fill_value_q  <= '0;
         data_buf_q    <= '0;
         mem_address_q <= '0;
         write_en_q    <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else if (!halt_sys) begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  src_ptr_q    <= src_addr;
                  dst_ptr_q    <= dst_addr;
                  remaining_q  <= length;
                  fill_mode_q  <= fill_mode;
                  fill_value_q <= fill_value;
                  busy_q       <= 1'b1;
                  if (length == 16'd0) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else if (fill_mode) begin
                     state_q       <= ST_WRITE;
                     mem_address_q <= dst_addr;
                     data_buf_q    <= fill_value;
                     write_en_q    <= 1'b1;
                  end else begin
                     state_q       <= ST_READ;
                     mem_address_q <= src_addr;
                  end
               end
            end
            ST_READ: begin
               data_buf_q    <= mem_bus.mem_data_in;
               src_ptr_q     <= src_ptr_d;
               mem_address_q <= dst_ptr_q;
               write_en_q    <= 1'b1;
               state_q       <= ST_WRITE;
            end
            ST_WRITE: begin
               dst_ptr_q   <= dst_ptr_d;
               remaining_q <= remaining_q - 16'd1;
               if (remaining_q == 16'd1) begin
                  state_q    <= ST_DONE;
                  write_en_q <= 1'b0;
                  done_q     <= 1'b1;
               end else if (fill_mode_q) begin
                  mem_address_q <= dst_ptr_d;
                  data_buf_q    <= fill_value_q;
               end else begin
                  state_q       <= ST_READ;
                  mem_address_q <= src_ptr_q;
                  write_en_q    <= 1'b0;
               end
            end
            ST_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               state_q    <= ST_IDLE;
               write_en_q <= 1'b0;
               busy_q     <= 1'b0;
               done_q     <= 1'b0;
            end
         endcase
      end
   end

   // A halted write must never reach memory, even mid-cycle.
   assign mem_bus.mem_write_en   = write_en_q & ~halt_sys;
   assign mem_bus.mem_address    = mem_address_q;
   assign mem_bus.mem_write_data = data_buf_q;
   assign busy                   = busy_q;
   assign done                   = done_q;

`ifdef MEM_DMA_CHECKSUM_EN
   logic [DATA_W-1:0] checksum_q;

   // Running sum of committed words, restarted by each accepted start.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         checksum_q <= '0;
      end else if (!halt_sys) begin
         if ((state_q == ST_IDLE) && start) begin
            checksum_q <= '0;
         end else if (state_q == ST_WRITE) begin
            checksum_q <= checksum_q + data_buf_q;
         end
      end
   end

   assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_mem_dma_engine.sv
// Directed, table-driven bench for mem_dma_engine with a behavioural 64K-word memory.
`timescale 1ns/1ps
module tb_mem_dma_engine;

   typedef struct {
      logic        fm;
      logic [15:0] src;
      logic [15:0] dst;
      logic [15:0] len;
      logic [15:0] fv;
      int          halt_at;
      int          halt_len;
      int          exp_lat;
      int          exp_wr;
      logic [15:0] a0;
      logic [15:0] d0;
      logic [15:0] a1;
      logic [15:0] d1;
      logic [15:0] ag;
      logic [15:0] dg;
      logic [15:0] ck;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        halt_sys = 1'b0;
   logic        start = 1'b0;
   logic        fill_mode = 1'b0;
   logic [15:0] src_addr = 16'h0000;
   logic [15:0] dst_addr = 16'h0000;
   logic [15:0] length = 16'h0000;
   logic [15:0] fill_value = 16'h0000;
   logic        busy;
   logic        done;
`ifdef MEM_DMA_CHECKSUM_EN
   logic [15:0] checksum;
`endif

   logic [15:0] mem [0:65535];
   logic        pl_en = 1'b0;
   logic [15:0] pl_addr = 16'h0000;
   logic [15:0] pl_data = 16'h0000;
   int          wr_cnt = 0;
   int          n_cmp = 0;
   int          n_err = 0;
   vec_t        vecs [0:6];

   mem_dma_engine_if #(.ADDR_W(16), .DATA_W(16)) bus ();

   mem_dma_engine #(.ADDR_W(16), .DATA_W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .halt_sys   (halt_sys),
      .start      (start),
      .fill_mode  (fill_mode),
      .src_addr   (src_addr),
      .dst_addr   (dst_addr),
      .length     (length),
      .fill_value (fill_value),
      .mem_bus    (bus),
      .busy       (busy),
      .done       (done)
`ifdef MEM_DMA_CHECKSUM_EN
      ,
      .checksum   (checksum)
`endif
   );

   always #5 clk = ~clk;

   assign bus.mem_data_in = mem[bus.mem_address];

   always @(posedge clk) begin
      if (bus.mem_write_en) begin
         mem[bus.mem_address] <= bus.mem_write_data;
         wr_cnt <= wr_cnt + 1;
      end else if (pl_en) begin
         mem[pl_addr] <= pl_data;
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic preload(input logic [15:0] a, input logic [15:0] d);
      @(negedge clk);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      @(posedge clk);
      #1 pl_en = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      int lat = -1;
      int gaps = 0;
      int halt_we = 0;
      int wr0;
      @(negedge clk);
      wr0 = wr_cnt;
      fill_mode = v.fm; src_addr = v.src; dst_addr = v.dst; length = v.len; fill_value = v.fv;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0; fill_mode = ~v.fm; src_addr = 16'hBEEF; dst_addr = 16'hCAFE;
      length = 16'h0007; fill_value = 16'hFFFF;
      for (int cyc = 1; cyc <= 60; cyc++) begin
         @(negedge clk);
         if (halt_sys && bus.mem_write_en) halt_we++;
         if (!busy) gaps++;
         if (done) begin
            lat = cyc;
            break;
         end
         if (cyc == v.halt_at) halt_sys = 1'b1;
         if (v.halt_len > 0 && cyc == v.halt_at + v.halt_len) halt_sys = 1'b0;
         // A start arriving mid-transfer must be ignored.
         if (cyc == 1) begin
            start = 1'b1; fill_mode = 1'b1; dst_addr = 16'h0500; length = 16'h0002; fill_value = 16'hDEAD;
         end
         if (cyc == 2) start = 1'b0;
      end
      start = 1'b0;
      halt_sys = 1'b0;
      check("done_latency", 32'(lat), 32'(v.exp_lat));
      check("busy_gaps", 32'(gaps), 32'd0);
      check("we_during_halt", 32'(halt_we), 32'd0);
      @(negedge clk);
      check("done_one_cycle", {31'd0, done}, 32'd0);
      check("busy_after_done", {31'd0, busy}, 32'd0);
      check("write_count", 32'(wr_cnt - wr0), 32'(v.exp_wr));
      check("first_word", {16'd0, mem[v.a0]}, {16'd0, v.d0});
      check("last_word", {16'd0, mem[v.a1]}, {16'd0, v.d1});
      check("guard_word", {16'd0, mem[v.ag]}, {16'd0, v.dg});
      check("busy_start_ignored", {16'd0, mem[16'h0500]}, {16'd0, 16'h5555});
`ifdef MEM_DMA_CHECKSUM_EN
      check("checksum", {16'd0, checksum}, {16'd0, v.ck});
`endif
   endtask

   initial begin
      int wr0;
      int done_seen;
      //           fm    src       dst       len      fv        h  hl lat wr a0        d0        a1        d1        ag        dg        ck
      vecs[0] = '{1'b0, 16'h0010, 16'h0100, 16'd4, 16'h0000, 0, 0, 9,  4, 16'h0100, 16'hA001, 16'h0103, 16'hA004, 16'h0104, 16'h1111, 16'h800A};
      vecs[1] = '{1'b1, 16'h0000, 16'hFFFE, 16'd4, 16'h5A5A, 0, 0, 5,  4, 16'hFFFE, 16'h5A5A, 16'h0001, 16'h5A5A, 16'h0002, 16'h2222, 16'h6968};
      vecs[2] = '{1'b0, 16'h0010, 16'h0800, 16'd0, 16'h0000, 0, 0, 1,  0, 16'h0800, 16'h8888, 16'h0800, 16'h8888, 16'h0800, 16'h8888, 16'h0000};
      vecs[3] = '{1'b0, 16'h0200, 16'h0300, 16'd3, 16'h0000, 0, 0, 7,  3, 16'h0300, 16'h8000, 16'h0302, 16'h0003, 16'h0303, 16'h3333, 16'h0004};
      vecs[4] = '{1'b1, 16'h0000, 16'h0400, 16'd1, 16'h1234, 0, 0, 2,  1, 16'h0400, 16'h1234, 16'h0400, 16'h1234, 16'h0401, 16'h4444, 16'h1234};
      vecs[5] = '{1'b0, 16'h0010, 16'h0700, 16'd3, 16'h0000, 4, 5, 12, 3, 16'h0700, 16'hA001, 16'h0702, 16'hA003, 16'h0703, 16'h7777, 16'hE006};
      vecs[6] = '{1'b1, 16'h0000, 16'h0603, 16'd1, 16'h0ABC, 0, 0, 2,  1, 16'h0603, 16'h0ABC, 16'h0603, 16'h0ABC, 16'h0604, 16'h6464, 16'h0ABC};

      for (int i = 0; i < 4; i++) preload(16'h0010 + 16'(i), 16'hA001 + 16'(i));
      preload(16'h0200, 16'h8000);
      preload(16'h0201, 16'h8001);
      preload(16'h0202, 16'h0003);
      preload(16'h0104, 16'h1111);
      preload(16'h0002, 16'h2222);
      preload(16'h0800, 16'h8888);
      preload(16'h0303, 16'h3333);
      preload(16'h0401, 16'h4444);
      preload(16'h0500, 16'h5555);
      preload(16'h0703, 16'h7777);
      preload(16'h0603, 16'h6363);
      preload(16'h0604, 16'h6464);

      @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_we", {31'd0, bus.mem_write_en}, 32'd0);
      check("rst_addr", {16'd0, bus.mem_address}, 32'd0);
      check("rst_wdata", {16'd0, bus.mem_write_data}, 32'd0);
      rst = 1'b1;

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // Reset in the middle of an 8-word fill after three committed writes.
      @(negedge clk);
      fill_mode = 1'b1; dst_addr = 16'h0600; length = 16'd8; fill_value = 16'h7777; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wr0 = wr_cnt;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_done", {31'd0, done}, 32'd0);
      check("mid_rst_we", {31'd0, bus.mem_write_en}, 32'd0);
      check("mid_rst_addr", {16'd0, bus.mem_address}, 32'd0);
      check("mid_rst_wdata", {16'd0, bus.mem_write_data}, 32'd0);
`ifdef MEM_DMA_CHECKSUM_EN
      check("mid_rst_checksum", {16'd0, checksum}, 32'd0);
`endif
      done_seen = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (done) done_seen++;
      end
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (done || busy) done_seen++;
      end
      check("mid_rst_no_done", 32'(done_seen), 32'd0);
      check("mid_rst_writes", 32'(wr_cnt - wr0), 32'd3);
      check("mid_rst_word2", {16'd0, mem[16'h0602]}, {16'd0, 16'h7777});
      check("mid_rst_word3", {16'd0, mem[16'h0603]}, {16'd0, 16'h6363});

      run_vec(vecs[6]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
